// File: rtl/elevador_pkg.sv
// -----------------------------------------------------------------------------
// elevador_pkg
// Shared definitions for the three-floor elevator controller:
//   - floor codes as reported by the A1/A0 sensor
//   - FSM state encoding and travel direction
//   - small helpers that turn a floor code into a one-hot call mask and
//     answer "is there a pending call above / below this floor?"
// Pending-call vectors are always ordered {segundo, primeiro, terreo}.
// -----------------------------------------------------------------------------
package elevador_pkg;

    typedef logic [1:0] andar_t;

    localparam andar_t ANDAR_T       = 2'b00;  // terreo
    localparam andar_t ANDAR_P       = 2'b01;  // primeiro
    localparam andar_t ANDAR_S       = 2'b10;  // segundo
    localparam andar_t ENTRE_ANDARES = 2'b11;  // sensor between floors

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        SUBINDO  = 2'b01,
        DESCENDO = 2'b10,
        PORTA    = 2'b11
    } estado_t;

    typedef enum logic {
        DIR_SOBE  = 1'b0,
        DIR_DESCE = 1'b1
    } direcao_t;

    // One-hot mask of a floor inside a {S,P,T} vector; the between-floors
    // code selects nothing.
    function automatic logic [2:0] mascara_andar(input andar_t andar);
        case (andar)
            ANDAR_T: return 3'b001;
            ANDAR_P: return 3'b010;
            ANDAR_S: return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Any pending call strictly above the given floor.
    function automatic logic tem_acima(input logic [2:0] pend, input andar_t andar);
        case (andar)
            ANDAR_T: return pend[2] | pend[1];
            ANDAR_P: return pend[2];
            default: return 1'b0;
        endcase
    endfunction

    // Any pending call strictly below the given floor.
    function automatic logic tem_abaixo(input logic [2:0] pend, input andar_t andar);
        case (andar)
            ANDAR_S: return pend[1] | pend[0];
            ANDAR_P: return pend[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/controle_elevador_if.sv
// -----------------------------------------------------------------------------
// controle_elevador_if
// Signal bundle between the floor selector / car sensors and the elevator
// controller.
//   CT, CP, CS      call lines per floor (level, from seletor_andar)
//   A1, A0          floor sensor; {A1,A0}=11 while between floors
//   motor_sobe      drive car up
//   motor_desce     drive car down
//   porta_aberta    door open
//   andar_atual     last floor confirmed by the sensor
//   chamadas_pend   pending calls {S,P,T}
// master: the side that produces calls/sensor and observes the car.
// slave : the controller itself.
// -----------------------------------------------------------------------------
interface controle_elevador_if;

    logic       CT;
    logic       CP;
    logic       CS;
    logic       A1;
    logic       A0;
    logic       motor_sobe;
    logic       motor_desce;
    logic       porta_aberta;
    logic [1:0] andar_atual;
    logic [2:0] chamadas_pend;

    modport master (
        output CT, CP, CS, A1, A0,
        input  motor_sobe, motor_desce, porta_aberta, andar_atual, chamadas_pend
    );

    modport slave (
        input  CT, CP, CS, A1, A0,
        output motor_sobe, motor_desce, porta_aberta, andar_atual, chamadas_pend
    );

endinterface

// File: rtl/controle_elevador_temporizador_porta.sv
// -----------------------------------------------------------------------------
// temporizador_porta
// Door dwell timer: a loadable down-counter that saturates at zero.
//   clk     system clock, rising edge
//   rst     synchronous reset, active-high (counter to 0)
//   carga   load TEMPO_PORTA-1 (door just opened)
//   retrig  load TEMPO_PORTA-1 (call at the open floor keeps the door open)
//   fim     counter is zero: the dwell has elapsed
// With a load on the entry edge, fim rises in the TEMPO_PORTA-th cycle of
// the open door, so the door stays open exactly TEMPO_PORTA cycles.
// LARG_TEMP must satisfy 2**LARG_TEMP > TEMPO_PORTA.
// -----------------------------------------------------------------------------
module temporizador_porta #(
    parameter int TEMPO_PORTA = 4,
    parameter int LARG_TEMP   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic carga,
    input  logic retrig,
    output logic fim
);

    localparam logic [LARG_TEMP-1:0] RECARGA = LARG_TEMP'(TEMPO_PORTA - 1);
    localparam logic [LARG_TEMP-1:0] UM      = LARG_TEMP'(1);

    logic [LARG_TEMP-1:0] contagem;

    // NOTE: registers are written with non-blocking assignments so every
    // flop samples values from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            contagem <= '0;
        end else if (carga || retrig) begin
            contagem <= RECARGA;
        end else if (contagem != '0) begin
            contagem <= contagem - UM;
        end
    end

    assign fim = (contagem == '0);

endmodule

// File: rtl/controle_elevador.sv
// -----------------------------------------------------------------------------
// controle_elevador
// Three-floor elevator controller with same-direction priority (SCAN).
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high; wins over everything
//   bus   controle_elevador_if.slave:
//           in : CT/CP/CS call lines, A1/A0 floor sensor
//           out: motor_sobe, motor_desce, porta_aberta (Moore, from state),
//                andar_atual, chamadas_pend
// Calls are latched into a pending vector; the FSM decides only from the
// registered pending vector and registered floor, so a call seen at edge k
// moves the car from edge k+1 on. Arrival while moving is taken from the
// live sensor: a valid code different from the registered floor.
// -----------------------------------------------------------------------------
module controle_elevador
    import elevador_pkg::*;
#(
    parameter int TEMPO_PORTA = 4,
    parameter int LARG_TEMP   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    controle_elevador_if.slave   bus
);

    estado_t    estado;
    estado_t    prox_estado;
    direcao_t   dir;
    direcao_t   prox_dir;
    logic [2:0] pend;
    logic [2:0] prox_pend;
    andar_t     andar;

    logic [2:0] chamadas;
    andar_t     sensor;
    logic       sensor_valido;
    logic       chegada;

    andar_t     andar_porta;   // floor at which the door would open
    logic       carga;
    logic       retrig;
    logic       fim;
    logic [2:0] bloqueia;
    logic [2:0] limpa;

    assign chamadas      = {bus.CS, bus.CP, bus.CT};
    assign sensor        = {bus.A1, bus.A0};
    assign sensor_valido = (sensor != ENTRE_ANDARES);
    assign chegada       = sensor_valido && (sensor != andar);

    // A call at the floor where the door is open holds the door instead of
    // becoming a pending request.
    assign retrig = (estado == PORTA) && ((chamadas & mascara_andar(andar)) != 3'b000);

    temporizador_porta #(
        .TEMPO_PORTA (TEMPO_PORTA),
        .LARG_TEMP   (LARG_TEMP)
    ) u_temporizador (
        .clk    (clk),
        .rst    (rst),
        .carga  (carga),
        .retrig (retrig),
        .fim    (fim)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        prox_estado = estado;
        prox_dir    = dir;
        andar_porta = andar;

        case (estado)
            PARADO: begin
                if ((pend & mascara_andar(andar)) != 3'b000) begin
                    prox_estado = PORTA;
                end else if (tem_acima(pend, andar)) begin
                    prox_estado = SUBINDO;
                    prox_dir    = DIR_SOBE;
                end else if (tem_abaixo(pend, andar)) begin
                    prox_estado = DESCENDO;
                    prox_dir    = DIR_DESCE;
                end
            end

            SUBINDO: begin
                if (chegada) begin
                    andar_porta = sensor;
                    if ((pend & mascara_andar(sensor)) != 3'b000) begin
                        prox_estado = PORTA;
                    end else if (!tem_acima(pend, sensor)) begin
                        // Also covers reaching the top floor: nothing is above.
                        prox_estado = PARADO;
                    end
                end
            end

            DESCENDO: begin
                if (chegada) begin
                    andar_porta = sensor;
                    if ((pend & mascara_andar(sensor)) != 3'b000) begin
                        prox_estado = PORTA;
                    end else if (!tem_abaixo(pend, sensor)) begin
                        prox_estado = PARADO;
                    end
                end
            end

            PORTA: begin
                if (fim && !retrig) begin
                    // Keep climbing if that was the heading and work remains
                    // above; otherwise serve below first, then above.
                    if ((dir == DIR_SOBE) && tem_acima(pend, andar)) begin
                        prox_estado = SUBINDO;
                    end else if (tem_abaixo(pend, andar)) begin
                        prox_estado = DESCENDO;
                        prox_dir    = DIR_DESCE;
                    end else if (tem_acima(pend, andar)) begin
                        prox_estado = SUBINDO;
                        prox_dir    = DIR_SOBE;
                    end else begin
                        prox_estado = PARADO;
                    end
                end
            end

            default: begin
                prox_estado = PARADO;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Call latch: set by any call line, cleared on the edge that opens the
    // door at that floor (clear wins), masked at the floor with an open door.
    // -------------------------------------------------------------------------
    assign carga     = (prox_estado == PORTA) && (estado != PORTA);
    assign limpa     = carga ? mascara_andar(andar_porta) : 3'b000;
    assign bloqueia  = (estado == PORTA) ? mascara_andar(andar) : 3'b000;
    assign prox_pend = (pend | (chamadas & ~bloqueia)) & ~limpa;

    // -------------------------------------------------------------------------
    // State, direction, pending calls and floor registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= PARADO;
            dir    <= DIR_SOBE;
            pend   <= 3'b000;
            andar  <= ANDAR_T;
        end else begin
            estado <= prox_estado;
            dir    <= prox_dir;
            pend   <= prox_pend;
            // Between-floors readings keep the last confirmed floor.
            if (sensor_valido) begin
                andar <= sensor;
            end
        end
    end

    // Moore outputs: one state drives at most one of the two motor lines.
    assign bus.motor_sobe    = (estado == SUBINDO);
    assign bus.motor_desce   = (estado == DESCENDO);
    assign bus.porta_aberta  = (estado == PORTA);
    assign bus.andar_atual   = andar;
    assign bus.chamadas_pend = pend;

endmodule

// File: tb/tb_controle_elevador.sv
// -----------------------------------------------------------------------------
// tb_controle_elevador
// Drives calls and a small car "plant" that produces the floor sensor, keeps
// a behavioural model of the elevator (integer floor, pending-call array,
// signed motion, door countdown), and pushes the expected outputs after each
// clock edge into a queue. A separate monitor pops one entry per cycle on the
// falling edge and compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_controle_elevador;

    localparam int TEMPO = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    controle_elevador_if bus ();

    controle_elevador #(
        .TEMPO_PORTA (TEMPO),
        .LARG_TEMP   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       sobe;
        logic       desce;
        logic       porta;
        logic [1:0] andar;
        logic [2:0] pend;
    } saida_t;

    saida_t exp_q[$];
    saida_t esperado;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the car
    int m_andar;      // confirmed floor 0..2
    bit m_pend[3];    // pending calls per floor
    int m_mov;        // +1 up, -1 down, 0 not moving
    bit m_porta;      // door open
    int m_resta;      // door cycles left after the current one
    int m_rumo;       // heading remembered between stops: +1 / -1

    // Car plant
    int car_pos = 0;
    int viagem  = 0;
    bit ruido   = 1'b0;

    task automatic check(input string nome, input logic [7:0] atual, input logic [7:0] req);
        total++;
        if (atual !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, atual, req, $time);
        end
    endtask

    function automatic bit acima(input int a);
        for (int i = a + 1; i < 3; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit abaixo(input int a);
        for (int i = 0; i < a; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock cycle: choose sensor, drive inputs, advance the model, queue
    // the expected outputs, then let the edge happen.
    task automatic step(input bit r, input bit [2:0] c);
        int  s;
        int  entra;
        int  bloq;
        bit  valido;

        if (m_mov != 0) begin
            if (viagem == 0) begin
                viagem = $urandom_range(3, 1);
                s = 3;
            end else begin
                viagem--;
                if (viagem == 0) begin
                    car_pos = car_pos + m_mov;
                    if (car_pos < 0) car_pos = 0;
                    if (car_pos > 2) car_pos = 2;
                    s = car_pos;
                end else begin
                    s = 3;
                end
            end
        end else begin
            viagem = 0;
            s = (ruido && $urandom_range(15, 0) == 0) ? 3 : car_pos;
        end

        rst    = r;
        bus.CT = c[0];
        bus.CP = c[1];
        bus.CS = c[2];
        bus.A1 = s[1];
        bus.A0 = s[0];

        if (r) begin
            m_andar = 0;
            m_pend  = '{0, 0, 0};
            m_mov   = 0;
            m_porta = 1'b0;
            m_resta = 0;
            m_rumo  = 1;
        end else begin
            entra  = -1;
            bloq   = m_porta ? m_andar : -1;
            valido = (s != 3);
            if (m_porta) begin
                if (c[m_andar]) begin
                    m_resta = TEMPO - 1;
                end else if (m_resta > 0) begin
                    m_resta--;
                end else begin
                    m_porta = 1'b0;
                    if (m_rumo > 0 && acima(m_andar)) m_mov = 1;
                    else if (abaixo(m_andar)) begin m_mov = -1; m_rumo = -1; end
                    else if (acima(m_andar))  begin m_mov = 1;  m_rumo = 1;  end
                end
            end else if (m_mov != 0) begin
                if (valido && s != m_andar) begin
                    if (m_pend[s]) entra = s;
                    else if (!((m_mov > 0 && acima(s)) || (m_mov < 0 && abaixo(s)))) m_mov = 0;
                end
            end else begin
                if (m_pend[m_andar]) entra = m_andar;
                else if (acima(m_andar))  begin m_mov = 1;  m_rumo = 1;  end
                else if (abaixo(m_andar)) begin m_mov = -1; m_rumo = -1; end
            end
            if (entra >= 0) begin
                m_porta = 1'b1;
                m_mov   = 0;
                m_resta = TEMPO - 1;
            end
            for (int f = 0; f < 3; f++) begin
                if (c[f] && f != bloq) m_pend[f] = 1'b1;
                if (f == entra)        m_pend[f] = 1'b0;
            end
            if (valido) m_andar = s;
        end

        esperado.sobe  = (m_mov > 0);
        esperado.desce = (m_mov < 0);
        esperado.porta = m_porta;
        esperado.andar = 2'(m_andar);
        esperado.pend  = {m_pend[2], m_pend[1], m_pend[0]};
        exp_q.push_back(esperado);

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 3'b000);
    endtask

    // Monitor: one expected entry per clock edge, compared mid-cycle.
    saida_t obs;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs = exp_q.pop_front();
            check("motor_sobe",    8'(bus.motor_sobe),    8'(obs.sobe));
            check("motor_desce",   8'(bus.motor_desce),   8'(obs.desce));
            check("porta_aberta",  8'(bus.porta_aberta),  8'(obs.porta));
            check("andar_atual",   8'(bus.andar_atual),   8'(obs.andar));
            check("chamadas_pend", 8'(bus.chamadas_pend), 8'(obs.pend));
            check("motores_excl",  8'(bus.motor_sobe & bus.motor_desce), 8'd0);
        end
    end

    initial begin
        int n;
        rst    = 1'b1;
        bus.CT = 1'b0;
        bus.CP = 1'b0;
        bus.CS = 1'b0;
        bus.A1 = 1'b0;
        bus.A0 = 1'b0;

        // Reset held two cycles, then idle.
        step(1'b1, 3'b000);
        step(1'b1, 3'b000);
        idle(10);

        // Call at the current floor: door only.
        step(1'b0, 3'b001);
        idle(8);

        // Up to the top floor.
        step(1'b0, 3'b100);
        idle(25);

        // From the top, two calls below: stop at 01, then 00.
        step(1'b0, 3'b011);
        idle(40);

        // SCAN: going up for S, T pressed en route together with P.
        step(1'b0, 3'b100);
        idle(2);
        step(1'b0, 3'b011);
        idle(45);

        // Door retrigger at 01 with a held button.
        step(1'b0, 3'b010);
        n = 0;
        while (!(m_porta && m_andar == 1) && n < 100) begin
            step(1'b0, 3'b000);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $display("FAIL espera_porta: got timeout expected door at floor 1");
        end
        for (int i = 0; i < 6; i++) step(1'b0, 3'b010);
        idle(6);

        // Reset while climbing.
        step(1'b0, 3'b100);
        n = 0;
        while (m_mov <= 0 && n < 30) begin
            step(1'b0, 3'b000);
            n++;
        end
        if (n >= 30) begin
            total++;
            bad++;
            $display("FAIL espera_subida: got timeout expected motion up");
        end
        step(1'b0, 3'b000);
        step(1'b1, 3'b000);
        idle(10);

        // Randomized traffic with sensor noise and occasional resets.
        ruido = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(299, 0) == 0,
                 {($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0)});
        end
        ruido = 1'b0;
        idle(5);

        @(negedge clk);
        #1;
        check("fila_vazia", 8'(exp_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/controle_elevador.md
Name: controle_elevador

Overview:
Sequential elevator controller for the 3-floor car (térreo 00, primeiro 01, segundo 10). It sits directly downstream of seletor_andar and consumes its per-floor call lines CT/CP/CS. It also takes the floor sensor A1/A0. It latches pending calls, tracks the current floor, drives motor up/down and door-open outputs, and serves calls with same-direction priority (SCAN).

Parameters:
TEMPO_PORTA, 4, door-open dwell in clock cycles (>=1)
LARG_TEMP, 3, door timer width; must satisfy 2^LARG_TEMP > TEMPO_PORTA

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
CT  input  1  call request, térreo (level, from seletor_andar)
CP  input  1  call request, primeiro
CS  input  1  call request, segundo
A1  input  1  floor sensor MSB
A0  input  1  floor sensor LSB; {A1,A0}=11 means between floors
motor_sobe  output  1  drive car up
motor_desce  output  1  drive car down
porta_aberta  output  1  door open
andar_atual  output  2  last floor confirmed by sensor
chamadas_pend  output  3  pending calls {S,P,T}

Behaviour:
- Reset, synchronous: state PARADO; pend=000; andar_atual=00; dir=up; timer=0; all motor/door outputs 0. rst wins over every other event. Reset mid-motion: outputs are 0 the cycle after the rst edge.
- Call latch: pend[f] is set on any clk edge where call line f=1. It is not set when f=andar_atual and the state is PORTA or entering PORTA; that case retriggers the door instead.
- pend[f] clears on the edge that enters PORTA at floor f. If set and clear occur together, clear wins.
- Floor tracking: andar_atual <= {A1,A0} whenever the sensor is valid (not 11). It holds while the sensor reads 11.
- Arrival: in SUBINDO/DESCENDO, the sensor is valid and differs from andar_atual.
- Outputs are Moore, decoded from the state register: motor_sobe=(SUBINDO), motor_desce=(DESCENDO), porta_aberta=(PORTA). motor_sobe and motor_desce are never both 1.
- Notation: "above" = any pend bit for a floor > andar_atual; "below" likewise.
- PARADO transitions, using registered pend:
  - pend[andar_atual] -> PORTA.
  - else above -> SUBINDO, dir=up.
  - else below -> DESCENDO, dir=down.
  - else stay.
- Latency: a call pulse sampled at edge k is visible in pend after k. The state changes at edge k+1, so the motor output rises after k+1.
- SUBINDO/DESCENDO, on arrival at floor f:
  - pend[f] -> PORTA.
  - else further calls in the current direction -> keep moving.
  - else -> PARADO.
- Floor 10 while SUBINDO and floor 00 while DESCENDO always leave the moving state.
- PORTA:
  - On entry the timer loads TEMPO_PORTA-1, then decrements each cycle.
  - porta_aberta is high for exactly TEMPO_PORTA cycles with no retrigger.
  - A call at andar_atual reloads the timer, so a held button keeps the door open.
  - At timer=0 with no retrigger, departure order:
    - dir=up and above -> SUBINDO.
    - below -> DESCENDO, dir=down.
    - above -> SUBINDO, dir=up.
    - else PARADO.
- Sensor glitches (11 or a changed code) in PARADO/PORTA only update andar_atual when the code is valid. They cause no state change.
- Illegal state encoding -> PARADO.

Decomposition:
- Shared package elevador_pkg: floor codes ANDAR_T=2'b00, ANDAR_P=2'b01, ANDAR_S=2'b10, ENTRE_ANDARES=2'b11; state encoding PARADO/SUBINDO/DESCENDO/PORTA; direction constants.
- One natural sub-module: temporizador_porta. It is a loadable down-counter with inputs carga and retrig, output fim, and parameters TEMPO_PORTA/LARG_TEMP.
- The FSM, call latch and floor register stay in controle_elevador.

Test Plan (TEMPO_PORTA=4):
- Assert rst 2 cycles, all inputs 0 -> motors 0, porta_aberta 0, andar_atual 00, chamadas_pend 000; held for 10 idle cycles.
- At 00, CT pulse 1 cycle -> pend 001 for one cycle, then porta_aberta=1 for exactly 4 cycles, pend 000, motors never 1, back to PARADO.
- At 00, CS pulse -> motor_sobe=1 after 2 edges. Sensor sequence 11,01 (no stop, motor_sobe stays 1), 11,10 -> motor off, door 4 cycles, andar_atual=10, pend 000.
- At 10, CT and CP both pulse -> DESCENDO, stop at 01 (door 4 cycles, pend 001), continue down, stop at 00, pend 000.
- SCAN: moving up from 00 with CS pending, CT pressed en route. Arrive 01 with CP pend -> door, then SUBINDO to 10 before returning to 00.
- Door retrigger plus reset: at 01 in PORTA, hold CP 6 cycles -> door open 6+4 cycles. Then a CS call; assert rst mid-SUBINDO -> next cycle motors 0, pend 000, andar_atual 00.
